frame_buffer_arbiter: RTL and testbench
=======================================

# frame_buffer_arbiter

Sits between the USB command path and the cube's single-port frame-buffer RAM, sharing that RAM between two requesters. The USB side issues chunk writes (panel/row/chunk address plus 32-bit chunk data); the display scanner issues word reads. USB writes are queued in a small FIFO. Display reads have priority, with a streak limit so queued writes are never starved. One memory command is issued per cycle, and read data returns with fixed latency.

## Interface
Parameters:
- FIFO_DEPTH, 4: write-queue entries (power of two, ≥2)
- MAX_RD_STREAK, 8: consecutive read grants allowed while writes are pending
- DATA_WIDTH, 32: chunk width
- ADDR_WIDTH, 10: {panel[1:0], row[3:0], chunk[3:0]}

Ports:
- clk  in  1  system clock; one clock domain, all logic on rising edge
- reset  in  1  synchronous, active-high
- wr_strobe  in  1  one-cycle chunk write request from USB controller
- wr_panel  in  2  panel address for the write
- wr_row  in  4  row address
- wr_chunk  in  4  chunk address
- wr_data  in  32  chunk data
- wr_overflow  out  1  sticky: a write was dropped on a full FIFO
- fifo_level  out  3  current queued write count, 0..FIFO_DEPTH
- rd_req  in  1  display read request
- rd_addr  in  10  display read address
- rd_grant  out  1  registered; request sampled at previous edge accepted
- rd_data_valid  out  1  rd_data holds the granted word
- rd_data  out  32  read data
- mem_addr  out  10  RAM address
- mem_wdata  out  32  RAM write data
- mem_we  out  1  RAM write enable
- mem_re  out  1  RAM read enable
- mem_rdata  in  32  RAM read data, valid one cycle after mem_re

## Operation
- Write address = {wr_panel, wr_row, wr_chunk}; the full address and data are pushed into the FIFO on wr_strobe.
- Push with FIFO full and no pop in the same cycle: entry dropped, wr_overflow set until reset. Push with FIFO full and a pop in the same cycle: entry accepted.
- Grant decision at every edge, one winner per edge:
  - if rd_req and (FIFO empty or streak < MAX_RD_STREAK): read wins;
  - else if FIFO non-empty: write wins (pops head);
  - else idle.
- Streak counter:
  - increments on each read grant while the FIFO is non-empty;
  - clears on a write grant or when the FIFO is empty;
  - saturates at MAX_RD_STREAK.
- State encoding (registered command): IDLE, RD, WR.
  - IDLE: mem_re = mem_we = 0.
  - RD: mem_re = 1, rd_grant = 1, mem_addr = captured rd_addr.
  - WR: mem_we = 1, mem_addr/mem_wdata = popped entry.
- No read-after-write forwarding. A read of an address with a queued write returns the old RAM contents.

## Timing
- Reset: all outputs 0, FIFO empty, streak 0, state IDLE.
- Reset mid-operation: queued writes discarded; an in-flight read produces no rd_data_valid.
- Read latency:
  - rd_req high in cycle N → rd_grant and mem_re in N+1;
  - rd_data_valid = 1 with rd_data = mem_rdata in N+2.
- Read handshake:
  - Requester holds rd_req/rd_addr stable until it sees rd_grant.
  - In the grant cycle it either deasserts or presents the next request, which allows back-to-back reads every cycle.
- Write latency with no contention: wr_strobe in cycle N → mem_we in N+2.
- fifo_level updates the cycle after a push or pop. A simultaneous push and pop leaves fifo_level unchanged.
- Worst-case write wait with continuous reads: MAX_RD_STREAK read grants, then one write.

## Structure
- Package frame_buffer_pkg:
  - ADDR_WIDTH and DATA_WIDTH constants;
  - arbiter state enum;
  - function building the address from {panel, row, chunk}.
- Sub-module chunk_write_fifo:
  - synchronous FIFO parameterised on depth and width (ADDR_WIDTH+DATA_WIDTH);
  - outputs full, empty and level.
- The arbiter FSM, streak counter and read-valid pipeline stage live in the top module.

## Test plan
- Reset then a single write (panel 2, row 5, chunk 3, data 0xDEADBEEF) → mem_we two cycles later, mem_addr = 0x253, mem_wdata = 0xDEADBEEF, fifo_level returns to 0.
- Single read of rd_addr 0x1A7 with RAM preloaded to 0x12345678 → rd_grant in N+1, rd_data_valid with 0x12345678 in N+2.
- rd_req held high continuously plus 1 queued write → exactly 8 read grants, then one mem_we, then reads resume.
- 5 wr_strobes on consecutive cycles while rd_req is held and the streak is not yet at the limit → 4 entries queued, 5th dropped, wr_overflow = 1 and stays 1 until reset.
- FIFO full, with a write grant and a wr_strobe in the same cycle → new entry accepted, fifo_level stays 4, wr_overflow stays 0.
- Assert reset with 3 writes queued and one read in flight → no mem_we, no rd_data_valid afterwards, all outputs 0, fifo_level 0.

Source files
------------

// File: rtl/frame_buffer_pkg.sv
// Shared widths, arbiter state encoding and address packing for the frame-buffer arbiter.
package frame_buffer_pkg;

   localparam int ADDR_WIDTH = 10;
   localparam int DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR
   } arb_state_t;

   function automatic logic [ADDR_WIDTH-1:0] make_addr(input logic [1:0] panel,
                                                       input logic [3:0] row,
                                                       input logic [3:0] chunk);
      return {panel, row, chunk};
   endfunction

endpackage

// File: rtl/frame_buffer_arbiter_if.sv
// Bundle of the USB write path, display read path and RAM command bus around the arbiter.
interface frame_buffer_arbiter_if #(parameter int LEVEL_WIDTH = 3) ();
   import frame_buffer_pkg::*;

   logic                   wr_strobe;
   logic [1:0]             wr_panel;
   logic [3:0]             wr_row;
   logic [3:0]             wr_chunk;
   logic [DATA_WIDTH-1:0]  wr_data;
   logic                   wr_overflow;
   logic [LEVEL_WIDTH-1:0] fifo_level;

   logic                   rd_req;
   logic [ADDR_WIDTH-1:0]  rd_addr;
   logic                   rd_grant;
   logic                   rd_data_valid;
   logic [DATA_WIDTH-1:0]  rd_data;

   logic [ADDR_WIDTH-1:0]  mem_addr;
   logic [DATA_WIDTH-1:0]  mem_wdata;
   logic                   mem_we;
   logic                   mem_re;
   logic [DATA_WIDTH-1:0]  mem_rdata;

   // The arbiter is the slave of both requesters and drives the RAM command bus.
   modport slave (
      input  wr_strobe, wr_panel, wr_row, wr_chunk, wr_data, rd_req, rd_addr, mem_rdata,
      output wr_overflow, fifo_level, rd_grant, rd_data_valid, rd_data,
             mem_addr, mem_wdata, mem_we, mem_re
   );

   modport master (
      output wr_strobe, wr_panel, wr_row, wr_chunk, wr_data, rd_req, rd_addr, mem_rdata,
      input  wr_overflow, fifo_level, rd_grant, rd_data_valid, rd_data,
             mem_addr, mem_wdata, mem_we, mem_re
   );

endinterface

// File: rtl/frame_buffer_arbiter_fifo.sv
// Synchronous write-queue FIFO; a push on a full FIFO is only taken when a pop frees a slot.
module chunk_write_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 42
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           push,
   input  logic [WIDTH-1:0]               wdata,
   input  logic                           pop,
   output logic [WIDTH-1:0]               rdata,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [LW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == LW'(DEPTH));
   assign empty   = (count == '0);
   assign level   = count;
   assign rdata   = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Shares the single-port frame-buffer RAM between queued USB chunk writes and display reads,
// giving reads priority up to a streak limit so pending writes always make progress.
module frame_buffer_arbiter
   import frame_buffer_pkg::*;
#(
   parameter int FIFO_DEPTH    = 4,
   parameter int MAX_RD_STREAK = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   frame_buffer_arbiter_if.slave  bus
);

   localparam int EW = ADDR_WIDTH + DATA_WIDTH;
   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = $clog2(MAX_RD_STREAK + 1);

   logic [EW-1:0]         push_entry;
   logic [EW-1:0]         head_entry;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [LW-1:0]         fifo_count;
   logic                  read_win;
   logic                  write_win;

   arb_state_t            state;
   logic [SW-1:0]         streak;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic                  rd_valid_q;
   logic                  overflow_q;

   assign push_entry = {make_addr(bus.wr_panel, bus.wr_row, bus.wr_chunk), bus.wr_data};

   chunk_write_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (bus.wr_strobe),
      .wdata (push_entry),
      .pop   (write_win),
      .rdata (head_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_count)
   );

   assign read_win  = bus.rd_req && (fifo_empty || (streak < SW'(MAX_RD_STREAK)));
   assign write_win = !read_win && !fifo_empty;

   // The streak never passes the limit: once it reaches it, a pending write wins and clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         streak      <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         rd_valid_q <= (state == RD);
         if (bus.wr_strobe && fifo_full && !write_win) begin
            overflow_q <= 1'b1;
         end
         if (read_win) begin
            state       <= RD;
            mem_addr_q  <= bus.rd_addr;
            mem_wdata_q <= '0;
         end else if (write_win) begin
            state                     <= WR;
            {mem_addr_q, mem_wdata_q} <= head_entry;
         end else begin
            state       <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
         end
         if (read_win && !fifo_empty) begin
            streak <= streak + 1'b1;
         end else begin
            streak <= '0;
         end
      end
   end

   assign bus.mem_re        = (state == RD);
   assign bus.rd_grant      = (state == RD);
   assign bus.mem_we        = (state == WR);
   assign bus.mem_addr      = mem_addr_q;
   assign bus.mem_wdata     = mem_wdata_q;
   assign bus.rd_data_valid = rd_valid_q;
   assign bus.rd_data       = rd_valid_q ? bus.mem_rdata : '0;
   assign bus.fifo_level    = fifo_count;
   assign bus.wr_overflow   = overflow_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed and randomized bench for frame_buffer_arbiter against a queue-based behavioural model.
module tb_frame_buffer_arbiter;
   import frame_buffer_pkg::*;

   localparam int DEPTH      = 4;
   localparam int MAX_STREAK = 8;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   frame_buffer_arbiter_if #(.LEVEL_WIDTH(3)) bus ();

   frame_buffer_arbiter #(
      .FIFO_DEPTH    (DEPTH),
      .MAX_RD_STREAK (MAX_STREAK)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Power-up RAM contents are a fixed pattern, with one word pinned for the single-read test.
   function automatic logic [31:0] init_word(input logic [9:0] a);
      if (a == 10'h1A7) return 32'h1234_5678;
      return 32'hC0DE_0000 | 32'(a);
   endfunction

   logic [31:0] ram     [1024];
   bit          ram_set [1024];

   function automatic logic [31:0] ram_read(input logic [9:0] a);
      return ram_set[a] ? ram[a] : init_word(a);
   endfunction

   always @(posedge clk) begin
      if (bus.mem_we) begin
         ram[bus.mem_addr]     <= bus.mem_wdata;
         ram_set[bus.mem_addr] <= 1'b1;
      end
      if (bus.mem_re) begin
         bus.mem_rdata <= ram_read(bus.mem_addr);
      end
   end

   // Reference model: write queue, streak count and expected command after each edge.
   logic [41:0] mq [$];
   int          m_streak;
   bit          m_ovf;
   bit          m_re;
   bit          m_we;
   bit          m_valid;
   logic [9:0]  m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic [31:0] mram     [1024];
   bit          mram_set [1024];

   function automatic logic [31:0] model_read(input logic [9:0] a);
      return mram_set[a] ? mram[a] : init_word(a);
   endfunction

   task automatic model_edge();
      bit          empty;
      bit          rd_win;
      bit          wr_win;
      logic [41:0] head;
      if (reset) begin
         mq.delete();
         m_streak = 0;
         m_ovf    = 0;
         m_re     = 0;
         m_we     = 0;
         m_valid  = 0;
         m_rdata  = '0;
         m_addr   = '0;
         m_wdata  = '0;
         return;
      end
      m_valid = m_re;
      m_rdata = m_re ? model_read(m_addr) : 32'h0;
      if (m_we) begin
         mram[m_addr]     = m_wdata;
         mram_set[m_addr] = 1;
      end
      empty    = (mq.size() == 0);
      rd_win   = bus.rd_req && (empty || m_streak < MAX_STREAK);
      wr_win   = !rd_win && !empty;
      m_streak = (rd_win && !empty) ? m_streak + 1 : 0;
      m_re     = rd_win;
      m_we     = wr_win;
      if (rd_win) begin
         m_addr = bus.rd_addr;
      end else if (wr_win) begin
         head    = mq.pop_front();
         m_addr  = head[41:32];
         m_wdata = head[31:0];
      end
      if (bus.wr_strobe) begin
         if (mq.size() < DEPTH) mq.push_back({bus.wr_panel, bus.wr_row, bus.wr_chunk, bus.wr_data});
         else m_ovf = 1;
      end
   endtask

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      check_output("rd_grant", 64'(bus.rd_grant), 64'(m_re));
      check_output("mem_re", 64'(bus.mem_re), 64'(m_re));
      check_output("mem_we", 64'(bus.mem_we), 64'(m_we));
      if (m_re || m_we) check_output("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
      if (m_we) check_output("mem_wdata", 64'(bus.mem_wdata), 64'(m_wdata));
      check_output("rd_data_valid", 64'(bus.rd_data_valid), 64'(m_valid));
      check_output("rd_data", 64'(bus.rd_data), m_valid ? 64'(m_rdata) : 64'd0);
      check_output("fifo_level", 64'(bus.fifo_level), 64'(mq.size()));
      check_output("wr_overflow", 64'(bus.wr_overflow), 64'(m_ovf));
   endtask

   // One clock: inputs already set, model advances on the edge, outputs compared 1 ns later.
   task automatic apply_stimulus();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic idle_inputs();
      bus.wr_strobe = 1'b0;
      bus.wr_panel  = '0;
      bus.wr_row    = '0;
      bus.wr_chunk  = '0;
      bus.wr_data   = '0;
      bus.rd_req    = 1'b0;
      bus.rd_addr   = '0;
   endtask

   task automatic random_write();
      bus.wr_strobe = 1'b1;
      bus.wr_panel  = 2'($urandom);
      bus.wr_row    = 4'($urandom);
      bus.wr_chunk  = 4'($urandom);
      bus.wr_data   = $urandom;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      apply_stimulus();
      reset = 1'b0;
   endtask

   initial begin
      int  grants;
      bit  seen_we;
      idle_inputs();
      reset = 1'b1;
      apply_stimulus();
      apply_stimulus();
      check_output("reset_mem_we", 64'(bus.mem_we), 64'd0);
      check_output("reset_mem_addr", 64'(bus.mem_addr), 64'd0);
      check_output("reset_level", 64'(bus.fifo_level), 64'd0);
      reset = 1'b0;

      $display("[TB] single write");
      bus.wr_strobe = 1'b1;
      bus.wr_panel  = 2'd2;
      bus.wr_row    = 4'd5;
      bus.wr_chunk  = 4'd3;
      bus.wr_data   = 32'hDEAD_BEEF;
      apply_stimulus();
      bus.wr_strobe = 1'b0;
      check_output("wr1_level_queued", 64'(bus.fifo_level), 64'd1);
      apply_stimulus();
      check_output("wr1_mem_we", 64'(bus.mem_we), 64'd1);
      check_output("wr1_mem_addr", 64'(bus.mem_addr), 64'h253);
      check_output("wr1_mem_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
      check_output("wr1_level_drained", 64'(bus.fifo_level), 64'd0);
      apply_stimulus();

      $display("[TB] single read");
      bus.rd_req  = 1'b1;
      bus.rd_addr = 10'h1A7;
      apply_stimulus();
      check_output("rd1_grant", 64'(bus.rd_grant), 64'd1);
      bus.rd_req = 1'b0;
      apply_stimulus();
      check_output("rd1_valid", 64'(bus.rd_data_valid), 64'd1);
      check_output("rd1_data", 64'(bus.rd_data), 64'h1234_5678);

      $display("[TB] read streak against one queued write");
      bus.rd_req  = 1'b1;
      bus.rd_addr = 10'($urandom);
      random_write();
      apply_stimulus();
      bus.wr_strobe = 1'b0;
      grants  = 0;
      seen_we = 0;
      for (int i = 0; i < 40 && !seen_we; i++) begin
         if (m_re) bus.rd_addr = 10'($urandom);
         apply_stimulus();
         if (bus.mem_we) seen_we = 1;
         else if (bus.rd_grant) grants++;
      end
      check_output("streak_write_seen", 64'(seen_we), 64'd1);
      check_output("streak_read_grants", 64'(grants), 64'(MAX_STREAK));
      apply_stimulus();
      check_output("streak_reads_resume", 64'(bus.rd_grant), 64'd1);
      bus.rd_req = 1'b0;
      apply_stimulus();

      $display("[TB] overflow on a full queue");
      do_reset();
      bus.rd_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (m_re) bus.rd_addr = 10'($urandom);
         random_write();
         apply_stimulus();
      end
      bus.wr_strobe = 1'b0;
      check_output("ovf_level_full", 64'(bus.fifo_level), 64'd4);
      check_output("ovf_flag_set", 64'(bus.wr_overflow), 64'd1);
      for (int i = 0; i < 30; i++) begin
         if (m_re) bus.rd_addr = 10'($urandom);
         apply_stimulus();
      end
      check_output("ovf_flag_sticky", 64'(bus.wr_overflow), 64'd1);

      $display("[TB] push accepted alongside a pop on a full queue");
      do_reset();
      bus.rd_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (m_re) bus.rd_addr = 10'($urandom);
         random_write();
         apply_stimulus();
      end
      bus.wr_strobe = 1'b0;
      for (int i = 0; i < 20 && m_streak < MAX_STREAK; i++) begin
         if (m_re) bus.rd_addr = 10'($urandom);
         apply_stimulus();
      end
      if (m_re) bus.rd_addr = 10'($urandom);
      random_write();
      apply_stimulus();
      bus.wr_strobe = 1'b0;
      check_output("full_pop_mem_we", 64'(bus.mem_we), 64'd1);
      check_output("full_pop_level", 64'(bus.fifo_level), 64'd4);
      check_output("full_pop_no_ovf", 64'(bus.wr_overflow), 64'd0);

      $display("[TB] reset mid-operation");
      do_reset();
      bus.rd_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (m_re) bus.rd_addr = 10'($urandom);
         random_write();
         apply_stimulus();
      end
      check_output("midrst_level_before", 64'(bus.fifo_level), 64'd3);
      check_output("midrst_read_inflight", 64'(bus.mem_re), 64'd1);
      do_reset();
      check_output("midrst_level", 64'(bus.fifo_level), 64'd0);
      check_output("midrst_mem_re", 64'(bus.mem_re), 64'd0);
      check_output("midrst_valid", 64'(bus.rd_data_valid), 64'd0);
      check_output("midrst_rd_data", 64'(bus.rd_data), 64'd0);
      check_output("midrst_mem_addr", 64'(bus.mem_addr), 64'd0);
      check_output("midrst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
      for (int i = 0; i < 5; i++) begin
         apply_stimulus();
         check_output("midrst_after_we", 64'(bus.mem_we), 64'd0);
         check_output("midrst_after_valid", 64'(bus.rd_data_valid), 64'd0);
      end

      $display("[TB] randomized traffic");
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom_range(99) == 0);
         if ($urandom_range(2) == 0) random_write();
         else bus.wr_strobe = 1'b0;
         if (!bus.rd_req || m_re) begin
            bus.rd_req  = ($urandom_range(3) != 0);
            bus.rd_addr = 10'($urandom);
         end
         apply_stimulus();
      end
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
